adc_stream_packer: RTL and testbench

Multi-channel ADC sample packer for the AD9643 capture path. It takes deserialised per-channel samples and overrange flags, converts them to sign-extended two's-complement words, and optionally decimates them. It frames the result into fixed-length AXI-Stream packets and buffers them in a FIFO that honours `m_axis_tready` backpressure. It sits downstream of the IDDR capture stage and upstream of the DMA / stream interconnect.

---
 rtl/adc_stream_packer.sv | 177 +++++++++++++++++
 tb/tb_adc_stream_packer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_stream_packer.sv
// AD9643 capture-path packer: offset-binary/two's-complement conversion, decimation,
// fixed-length AXI-Stream framing and a first-word-fall-through output FIFO.
module adc_stream_packer #(
    parameter int NUM_CH     = 2,
    parameter int ADC_WIDTH  = 14,
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TWOS_COMP  = 0
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_areset,
    input  logic                          adc_valid,
    input  logic [NUM_CH*ADC_WIDTH-1:0]   adc_data,
    input  logic [NUM_CH-1:0]             adc_or,
    input  logic                          cfg_enable,
    input  logic [7:0]                    cfg_decim,
    input  logic [15:0]                   cfg_frame_len,
    input  logic                          cfg_or_drop,
    input  logic                          or_clear,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [NUM_CH*OUT_WIDTH-1:0]   m_axis_tdata,
    output logic [NUM_CH-1:0]             m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic [15:0]                   ovf_count,
    output logic [NUM_CH-1:0]             or_sticky,
    output logic                          busy
);

    localparam int LANES_W = NUM_CH * OUT_WIDTH;
    localparam int ENTRY_W = LANES_W + NUM_CH + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [7:0]          decim_sh;
    logic [15:0]         len_sh;
    logic                drop_sh;
    logic [7:0]          dcnt;
    logic [15:0]         bcnt;

    logic                s1_valid;
    logic [LANES_W-1:0]  s1_data;
    logic [NUM_CH-1:0]   s1_or;

    logic [LANES_W-1:0]  conv_data;
    logic                start;
    logic                or_hit;
    logic                eligible;
    logic                wr_en;
    logic                wr_last;
    logic                frame_done;
    logic                fifo_full;
    logic                pop;

    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    function automatic logic [OUT_WIDTH-1:0] convert(input logic [ADC_WIDTH-1:0] raw);
        logic [ADC_WIDTH-1:0] s;
        s = raw;
        if (TWOS_COMP == 0)
            s[ADC_WIDTH-1] = ~s[ADC_WIDTH-1];
        return OUT_WIDTH'(signed'(s));
    endfunction

    always_comb begin
        conv_data = '0;
        for (int unsigned k = 0; k < NUM_CH; k++)
            conv_data[k*OUT_WIDTH +: OUT_WIDTH] = convert(adc_data[k*ADC_WIDTH +: ADC_WIDTH]);
    end

    // The beat arriving on the edge that closes a frame belongs to no packet,
    // so it is killed here rather than leaking into the next one.
    always_comb begin
        start      = (state == IDLE) && adc_valid && cfg_enable;
        or_hit     = |adc_or;
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        wr_en      = s1_valid && !fifo_full;
        wr_last    = (bcnt == len_sh - 16'd1);
        frame_done = (state == RUN) && wr_en && wr_last;
        if (state == IDLE)
            eligible = start && !(cfg_or_drop && or_hit);
        else
            eligible = adc_valid && (dcnt == '0) && !frame_done && !(drop_sh && or_hit);
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state     <= IDLE;
            decim_sh  <= '0;
            len_sh    <= 16'd1;
            drop_sh   <= 1'b0;
            dcnt      <= '0;
            bcnt      <= '0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_or     <= '0;
            ovf_count <= '0;
            or_sticky <= '0;
        end else begin
            s1_valid <= eligible;
            s1_data  <= conv_data;
            s1_or    <= adc_or;

            case (state)
                IDLE: begin
                    dcnt <= '0;
                    bcnt <= '0;
                    if (start) begin
                        decim_sh <= cfg_decim;
                        len_sh   <= (cfg_frame_len == '0) ? 16'd1 : cfg_frame_len;
                        drop_sh  <= cfg_or_drop;
                        dcnt     <= (cfg_decim == '0) ? 8'd0 : 8'd1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (adc_valid)
                        dcnt <= (dcnt == decim_sh) ? 8'd0 : dcnt + 8'd1;
                    if (wr_en) begin
                        if (wr_last) begin
                            bcnt  <= '0;
                            dcnt  <= '0;
                            state <= IDLE;
                        end else begin
                            bcnt <= bcnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (s1_valid && fifo_full && ovf_count != '1)
                ovf_count <= ovf_count + 16'd1;

            if (adc_valid)
                or_sticky <= (or_clear ? '0 : or_sticky) | adc_or;
            else if (or_clear)
                or_sticky <= '0;
        end
    end

    assign pop = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge m_axi_aclk) begin
        if (wr_en)
            mem[wr_ptr] <= {wr_last, s1_or, s1_data};
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(wr_en) - CNT_W'(pop);
        end
    end

    // Head entry drives the stream directly; payload reads as zero while empty.
    always_comb begin
        m_axis_tvalid = (count != '0);
        {m_axis_tlast, m_axis_tuser, m_axis_tdata} = m_axis_tvalid ? mem[rd_ptr] : '0;
    end

    assign busy = (state == RUN) || (count != '0);

endmodule

// File: tb/tb_adc_stream_packer.sv
// Scoreboard bench for adc_stream_packer: directed scenarios plus randomized frames
// checked against a per-beat reference model of eligibility, conversion and framing.
module tb_adc_stream_packer;

    localparam int NUM_CH = 2;
    localparam int ADC_W  = 14;
    localparam int OUT_W  = 16;
    localparam int DEPTH  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    adc_valid;
    logic [NUM_CH*ADC_W-1:0] adc_data;
    logic [NUM_CH-1:0]       adc_or;
    logic                    cfg_enable;
    logic [7:0]              cfg_decim;
    logic [15:0]             cfg_frame_len;
    logic                    cfg_or_drop;
    logic                    or_clear;
    logic                    tvalid;
    logic                    tready;
    logic [NUM_CH*OUT_W-1:0] tdata;
    logic [NUM_CH-1:0]       tuser;
    logic                    tlast;
    logic [15:0]             ovf_count;
    logic [NUM_CH-1:0]       or_sticky;
    logic                    busy;

    adc_stream_packer #(
        .NUM_CH(NUM_CH), .ADC_WIDTH(ADC_W), .OUT_WIDTH(OUT_W),
        .FIFO_DEPTH(DEPTH), .TWOS_COMP(0)
    ) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst),
        .adc_valid(adc_valid), .adc_data(adc_data), .adc_or(adc_or),
        .cfg_enable(cfg_enable), .cfg_decim(cfg_decim), .cfg_frame_len(cfg_frame_len),
        .cfg_or_drop(cfg_or_drop), .or_clear(or_clear),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
        .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .ovf_count(ovf_count), .or_sticky(or_sticky), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  user;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [27:0] sd[$];
    logic [1:0]  so[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rdy_mode = 1;
    int          start_cyc = 0;
    int          rise_cyc = 0;
    logic        tv_prev = 1'b0;
    logic        stall_prev = 1'b0;
    logic [34:0] stall_snap;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tready = 1'b0;
            1:       tready = 1'b1;
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Offset binary to signed: subtract mid-scale, keep as 16-bit two's complement.
    function automatic logic [15:0] ref_lane(input logic [13:0] raw);
        int v;
        v = int'(raw) - 8192;
        return v[15:0];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_tvalid", 32'(tvalid), 32'd1);
                check("stall_payload", 32'({tlast, tuser, tdata} ^ stall_snap), 32'd0);
            end
            if (tvalid && !tv_prev)
                rise_cyc = cyc;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got tdata %h with no beat expected", tdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("tdata", tdata, e.data);
                    check("tuser", 32'(tuser), 32'(e.user));
                    check("tlast", 32'(tlast), 32'(e.last));
                end
            end
            stall_prev = tvalid && !tready;
            stall_snap = {tlast, tuser, tdata};
        end
        tv_prev = tvalid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: beats indexed from the start beat; every (decim+1)th is eligible,
    // overrange beats drop in drop mode, first len survivors form the packet.
    task automatic run_frame(input int decim, input int len, input bit drop,
                             input int en_beats, input int extra, input bit gaps);
        int   eff_len;
        int   got;
        int   done_idx;
        int   nfeed;
        int   en_n;
        exp_t e;
        eff_len  = (len == 0) ? 1 : len;
        got      = 0;
        done_idx = -1;
        for (int i = 0; i < sd.size(); i++) begin
            if (got < eff_len && (i % (decim + 1)) == 0 && !(drop && so[i] != 2'b00)) begin
                e.data = {ref_lane(sd[i][27:14]), ref_lane(sd[i][13:0])};
                e.user = so[i];
                e.last = (got == eff_len - 1);
                exp_q.push_back(e);
                got++;
                if (got == eff_len) done_idx = i;
            end
        end
        nfeed = (done_idx < 0) ? sd.size() : done_idx + 1 + extra;
        if (nfeed > sd.size()) nfeed = sd.size();
        en_n = en_beats;
        if (done_idx >= 0 && en_n > done_idx + 1) en_n = done_idx + 1;
        cfg_decim     = 8'(decim);
        cfg_frame_len = 16'(len);
        cfg_or_drop   = drop;
        for (int i = 0; i < nfeed; i++) begin
            if (gaps) begin
                adc_valid = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            adc_valid  = 1'b1;
            adc_data   = sd[i];
            adc_or     = so[i];
            cfg_enable = (i < en_n);
            if (i == 0) start_cyc = cyc;
            step();
        end
        adc_valid  = 1'b0;
        adc_or     = '0;
        cfg_enable = 1'b0;
    endtask

    task automatic wait_drain(input bit need_idle);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || (need_idle && busy)) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", {30'd0, exp_q.size() == 0, need_idle && busy}, 32'b10);
        step();
    endtask

    initial begin
        rst = 1'b1; adc_valid = 1'b0; adc_data = '0; adc_or = '0;
        cfg_enable = 1'b0; cfg_decim = '0; cfg_frame_len = '0;
        cfg_or_drop = 1'b0; or_clear = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_tuser", 32'(tuser), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_ovf", 32'(ovf_count), 32'd0);
        check("rst_sticky", 32'(or_sticky), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        step();

        // Conversion and framing, with first-beat latency.
        rdy_mode = 1;
        sd.delete(); so.delete();
        for (int i = 0; i < 4; i++) begin
            sd.push_back({14'h3FFF, 14'(i)});
            so.push_back(2'b00);
        end
        run_frame(0, 4, 1'b0, 4, 0, 1'b0);
        wait_drain(1'b1);
        check("first_latency", 32'(rise_cyc - start_cyc), 32'd2);

        // Decimation: samples 0,3,6 then nothing from 9 onward.
        sd.delete(); so.delete();
        for (int i = 0; i < 12; i++) begin
            sd.push_back({14'(i + 100), 14'(i)});
            so.push_back(2'b00);
        end
        run_frame(2, 3, 1'b0, 1, 12, 1'b0);
        wait_drain(1'b1);

        // Overrange, drop mode then pass mode.
        or_clear = 1'b1; step(); or_clear = 1'b0;
        sd.delete(); so.delete();
        for (int i = 0; i < 5; i++) begin
            sd.push_back(28'($urandom));
            so.push_back(i == 1 ? 2'b01 : 2'b00);
        end
        run_frame(0, 4, 1'b1, 1, 1, 1'b0);
        wait_drain(1'b1);
        check("or_sticky_drop", 32'(or_sticky), 32'b01);
        run_frame(0, 4, 1'b0, 1, 1, 1'b0);
        wait_drain(1'b1);
        check("or_sticky_pass", 32'(or_sticky), 32'b01);
        or_clear = 1'b1; step(); or_clear = 1'b0;
        check("or_clear", 32'(or_sticky), 32'd0);

        // Enable dropped mid-frame: packet still completes.
        sd.delete(); so.delete();
        for (int i = 0; i < 10; i++) begin
            sd.push_back(28'($urandom));
            so.push_back(2'b00);
        end
        run_frame(0, 6, 1'b0, 3, 4, 1'b0);
        wait_drain(1'b1);
        check("busy_after_frame", 32'(busy), 32'd0);

        // Backpressure: 12 eligible beats into an 8-deep FIFO with no ready.
        rdy_mode = 0;
        step(); step();
        cfg_decim = 8'd0; cfg_frame_len = 16'd12; cfg_or_drop = 1'b0;
        for (int i = 0; i < 12; i++) begin
            logic [27:0] d;
            exp_t        e;
            d = 28'($urandom);
            if (i < DEPTH) begin
                e.data = {ref_lane(d[27:14]), ref_lane(d[13:0])};
                e.user = 2'b00;
                e.last = 1'b0;
                exp_q.push_back(e);
            end
            adc_valid = 1'b1; adc_data = d; adc_or = '0; cfg_enable = (i == 0);
            step();
        end
        adc_valid = 1'b0; cfg_enable = 1'b0;
        repeat (3) step();
        check("ovf_count", 32'(ovf_count), 32'd4);
        check("full_tvalid", 32'(tvalid), 32'd1);
        rdy_mode = 1;
        wait_drain(1'b0);

        // Reset mid-frame with beats queued.
        rdy_mode = 0;
        step(); step();
        for (int i = 0; i < 3; i++) begin
            adc_valid = 1'b1; adc_data = 28'($urandom); adc_or = '0;
            step();
        end
        adc_valid = 1'b0;
        repeat (3) step();
        check("pre_reset_tvalid", 32'(tvalid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("post_reset_tvalid", 32'(tvalid), 32'd0);
        check("post_reset_ovf", 32'(ovf_count), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);
        step();
        rdy_mode = 1;
        sd.delete(); so.delete();
        for (int i = 0; i < 4; i++) begin
            sd.push_back(28'($urandom));
            so.push_back(2'b00);
        end
        run_frame(0, 4, 1'b0, 1, 0, 1'b0);
        wait_drain(1'b1);

        // Randomized frames with random ready, gaps, overrange and lengths 0..DEPTH.
        rdy_mode = 2;
        for (int s = 0; s < 25; s++) begin
            sd.delete(); so.delete();
            for (int i = 0; i < 100; i++) begin
                sd.push_back(28'($urandom));
                so.push_back(($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            end
            run_frame($urandom_range(0, 3), $urandom_range(0, DEPTH), 1'($urandom_range(0, 1)),
                      $urandom_range(1, 4), $urandom_range(0, 3), 1'b1);
            wait_drain(1'b1);
        end
        check("final_ovf", 32'(ovf_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
